// File: rtl/apb_pkg.sv
// Shared types and sizing for the APB request-side bridge.
// Widths here set the host request format and the APB fan-out bus.
package apb_pkg;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int PORT_W    = 3;
    localparam int NUM_PORTS = 6;
    localparam int TIMEOUT   = 256;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    typedef struct packed {
        logic              we;
        logic [PORT_W-1:0] port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } apb_rsp_t;
endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-cycle counter for bus bridges: counts while inc is high, flags the
// last permitted cycle so the owner can abort a hung transfer.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt_reg;

    // The owner leaves the waiting state at TIMEOUT-1, so the counter never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/apb_bridge_master.sv
// Host valid/ready to APB SETUP/ACCESS bridge with illegal-port decode
// and a bounded ACCESS wait so a hung peripheral still gets a response.
module apb_bridge_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT = apb_pkg::TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [PORT_W+ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     apb_psel,
    output logic                     apb_en,
    output logic                     apb_wr,
    output logic [PORT_W-1:0]        apb_sel_port,
    output logic [ADDR_W-1:0]        apb_addr,
    output logic [DATA_W-1:0]        apb_wdata,
    input  logic                     apb_ready,
    input  logic [DATA_W-1:0]        apb_rdata
);
    apb_state_t state_reg, state_next;
    apb_req_t   req_reg, req_next;
    apb_rsp_t   rsp_reg, rsp_next;
    logic       expired;
    logic       port_ok;
    logic       busy;

    assign port_ok = (int'(req_addr[ADDR_W +: PORT_W]) < NUM_PORTS);

    apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_reg != ACCESS),
        .inc     (state_reg == ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            req_reg   <= '0;
            rsp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            rsp_reg   <= rsp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        rsp_next   = rsp_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_next.we    = req_we;
                    req_next.port  = req_addr[ADDR_W +: PORT_W];
                    req_next.addr  = req_addr[ADDR_W-1:0];
                    req_next.wdata = req_wdata;
                    if (port_ok) begin
                        state_next = SETUP;
                    end else begin
                        // Unmapped port: answer immediately, never touch the bus.
                        rsp_next.rdata = '0;
                        rsp_next.err   = 1'b1;
                        state_next     = RESP;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // A ready on the final permitted cycle still completes normally.
                if (apb_ready) begin
                    rsp_next.rdata = req_reg.we ? '0 : apb_rdata;
                    rsp_next.err   = 1'b0;
                    state_next     = RESP;
                end else if (expired) begin
                    rsp_next.rdata = '0;
                    rsp_next.err   = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy         = (state_reg == SETUP) || (state_reg == ACCESS);
    assign req_ready    = (state_reg == IDLE) && rst;
    assign apb_psel     = busy;
    assign apb_en       = (state_reg == ACCESS);
    assign apb_wr       = busy && req_reg.we;
    assign apb_sel_port = busy ? req_reg.port  : '0;
    assign apb_addr     = busy ? req_reg.addr  : '0;
    assign apb_wdata    = busy ? req_reg.wdata : '0;
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_rdata    = rsp_valid ? rsp_reg.rdata : '0;
    assign rsp_err      = rsp_valid && rsp_reg.err;
endmodule

// File: tb/tb_apb_bridge_master.sv
// Randomized bench for apb_bridge_master: a transaction-level model predicts
// the APB phase sequence, latency and response of each host request.
module tb_apb_bridge_master;
    localparam int TB_PORTS   = 6;
    localparam int TB_TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        apb_psel;
    logic        apb_en;
    logic        apb_wr;
    logic [2:0]  apb_sel_port;
    logic [11:0] apb_addr;
    logic [31:0] apb_wdata;
    logic        apb_ready = 1'b0;
    logic [31:0] apb_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    apb_bridge_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .apb_psel     (apb_psel),
        .apb_en       (apb_en),
        .apb_wr       (apb_wr),
        .apb_sel_port (apb_sel_port),
        .apb_addr     (apb_addr),
        .apb_wdata    (apb_wdata),
        .apb_ready    (apb_ready),
        .apb_rdata    (apb_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] all_outs();
        return {req_ready, rsp_valid, rsp_err, apb_psel, apb_en, apb_wr, apb_sel_port,
                apb_addr, apb_wdata, rsp_rdata[15:0]};
    endfunction

    // One host transaction. wait_n = ACCESS cycles the peripheral stalls before
    // ready (ready lands on ACCESS cycle wait_n+1); bp_n = cycles of rsp_ready=0.
    task automatic run_txn(input logic we, input logic [14:0] addr, input logic [31:0] wdata,
                           input int wait_n, input int bp_n, input logic [31:0] pdata);
        logic        legal;
        logic        err_exp;
        logic [31:0] rd_exp;
        logic [2:0]  port;
        int          acc_exp;
        int          lat_exp;
        int          lat;
        bit          got;
        bit          hold_bad;
        bit          psel_bad;
        bit          busy_bad;

        port     = addr[14:12];
        legal    = int'(port) < TB_PORTS;
        acc_exp  = (wait_n + 1 < TB_TIMEOUT) ? wait_n + 1 : TB_TIMEOUT;
        err_exp  = !legal || (wait_n + 1 > TB_TIMEOUT);
        lat_exp  = legal ? 2 + acc_exp : 1;
        rd_exp   = (!err_exp && !we) ? pdata : 32'd0;
        got      = 0;
        lat      = 0;
        hold_bad = 0;
        psel_bad = 0;
        busy_bad = 0;

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        check("req_ready_idle", req_ready, 1);

        for (int k = 1; k <= TB_TIMEOUT + 20; k++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            apb_ready = 1'b0;
            apb_rdata = $urandom;
            if (rsp_valid) begin
                got = 1;
                lat = k;
                break;
            end
            if (req_ready) busy_bad = 1;
            if (!legal && apb_psel) psel_bad = 1;
            if (legal && k == 1) begin
                check("setup_psel_en", {apb_psel, apb_en}, 2'b10);
                check("setup_wr", apb_wr, we);
                check("setup_port", apb_sel_port, port);
                check("setup_addr", apb_addr, addr[11:0]);
                check("setup_wdata", apb_wdata, wdata);
            end else if (legal && k - 1 <= acc_exp) begin
                if (!(apb_psel && apb_en && apb_wr == we && apb_sel_port == port &&
                      apb_addr == addr[11:0] && apb_wdata == wdata))
                    hold_bad = 1;
                if (k - 1 == wait_n + 1) begin
                    apb_ready = 1'b1;
                    apb_rdata = pdata;
                end
            end
        end
        apb_ready = 1'b0;

        check("rsp_seen", got, 1);
        if (!got) return;
        $display("[TB] txn we=%0d addr=%h wait=%0d bp=%0d lat=%0d err=%0d rdata=%h",
                 we, addr, wait_n, bp_n, lat, rsp_err, rsp_rdata);
        check("rsp_latency", lat, lat_exp);
        check("rsp_err", rsp_err, err_exp);
        check("rsp_rdata", rsp_rdata, rd_exp);
        check("busy_req_ready", busy_bad, 0);
        check("resp_bus_idle", {apb_psel, apb_en, apb_wr, apb_sel_port, apb_addr, apb_wdata}, 0);
        if (legal) check("access_stable", hold_bad, 0);
        else check("illegal_no_psel", psel_bad, 0);

        for (int b = 0; b < bp_n; b++) begin
            @(posedge clk);
            #1;
            check("bp_held", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, err_exp, rd_exp});
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", rsp_valid, 0);
        check("post_hs_req_ready", req_ready, 1);
    endtask

    task automatic reset_during_access();
        bit stray;
        stray     = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 15'h2040;
        req_wdata = 32'h1234_5678;
        repeat (4) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        check("pre_rst_access", {apb_psel, apb_en}, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 0);
        $display("[TB] async reset asserted during ACCESS");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", req_ready, 1);
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid || apb_psel) stray = 1;
        end
        check("no_stale_rsp", stray, 0);
    endtask

    initial begin
        #1;
        check("reset_outs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_idle_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);

        run_txn(1'b1, 15'h3300, 32'd13, 0, 0, $urandom);
        run_txn(1'b0, 15'h5010, $urandom, 3, 0, 32'hDEADBEEF);
        run_txn(1'b0, 15'h6123, $urandom, 0, 0, $urandom);
        run_txn(1'b1, 15'h7abc, $urandom, 0, 1, $urandom);
        run_txn(1'b0, 15'h1004, $urandom, 1000, 0, $urandom);
        run_txn(1'b0, 15'h0ffc, $urandom, TB_TIMEOUT - 1, 0, 32'hCAFE_F00D);
        run_txn(1'b0, 15'h4444, $urandom, 2, 5, 32'h0BAD_BEEF);
        run_txn(1'b1, 15'h2222, 32'h5555_AAAA, 0, 0, $urandom);
        reset_during_access();

        for (int t = 0; t < 40; t++) begin
            logic        we;
            logic [14:0] addr;
            int          wt;
            we   = 1'($urandom_range(0, 1));
            addr = 15'($urandom);
            wt   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 30) : $urandom_range(0, 5);
            run_txn(we, addr, $urandom, wt, $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
